alu_seq_unit: RTL

- Sequential 8-bit ALU directly downstream of the register file.
- Consumes the register file's two read ports (dataout_A, dataout_B) and produces the write-back value on ALU_IN, which the register file selects through its mux_sel path.
- Single-cycle ops for arithmetic, logic and rotate; multi-cycle shift-add multiply.
- Start/done handshake and a registered flag set (CY, Z, S, P) for the controller.

---
 rtl/alu_seq_unit_if.sv | 25 ++
 rtl/alu_seq_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit_if.sv
// Register-file-to-ALU bundle: operand read ports in, write-back value, flags and handshake out.
interface alu_seq_unit_if #(parameter int DATA_W = 8);
  logic              start;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] dataout_A;
  logic [DATA_W-1:0] dataout_B;
  logic [DATA_W-1:0] ALU_IN;
  logic [DATA_W-1:0] res_hi;
  logic              busy;
  logic              done;
  logic              flag_cy;
  logic              flag_z;
  logic              flag_s;
  logic              flag_p;

  modport master (
    output start, opcode, dataout_A, dataout_B,
    input  ALU_IN, res_hi, busy, done, flag_cy, flag_z, flag_s, flag_p
  );

  modport slave (
    input  start, opcode, dataout_A, dataout_B,
    output ALU_IN, res_hi, busy, done, flag_cy, flag_z, flag_s, flag_p
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle arith/logic/rotate, optional shift-add multiply.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode D acts as NOP.
module alu_seq_unit #(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_unit_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBB = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_CMP = 4'h7,
    OP_INR = 4'h8, OP_DCR = 4'h9, OP_RLC = 4'hA, OP_RRC = 4'hB,
    OP_NOT = 4'hC, OP_MUL = 4'hD, OP_PSB = 4'hE, OP_NOP = 4'hF
  } opcode_t;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  localparam logic [DATA_W:0] ONE = (DATA_W+1)'(1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              cy_q, cy_d, z_q, z_d, s_q, s_d, p_q, p_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   ext;
  logic [DATA_W-1:0] zsp_v;
  logic              upd_zsp;
  opcode_t           op;

`ifdef ALU_MUL_EN
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] b_q, b_d, plo_q, plo_d, phi_q, phi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] mul_hi, mul_lo;
  logic              mul_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cy_d    = cy_q;
    z_d     = z_q;
    s_d     = s_q;
    p_d     = p_q;
    done_d  = 1'b0;
    ext     = '0;
    zsp_v   = '0;
    upd_zsp = 1'b0;
    op      = opcode_t'(bus.opcode);
`ifdef ALU_MUL_EN
    hi_d     = hi_q;
    b_d      = b_q;
    plo_d    = plo_q;
    phi_d    = phi_q;
    cnt_d    = cnt_q;
    // Product lives in {phi, plo}; plo starts as A and its LSB selects the add.
    mul_sum  = {1'b0, phi_q} + (plo_q[0] ? {1'b0, b_q} : '0);
    mul_hi   = mul_sum[DATA_W:1];
    mul_lo   = {mul_sum[0], plo_q[DATA_W-1:1]};
    mul_last = (cnt_q == CNT_W'(DATA_W-1));
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          done_d = 1'b1;
          case (op)
            OP_ADD: ext = {1'b0, bus.dataout_A} + {1'b0, bus.dataout_B};
            OP_ADC: ext = {1'b0, bus.dataout_A} + {1'b0, bus.dataout_B} + {{DATA_W{1'b0}}, cy_q};
            OP_SUB, OP_CMP: ext = {1'b0, bus.dataout_A} - {1'b0, bus.dataout_B};
            OP_SBB: ext = {1'b0, bus.dataout_A} - {1'b0, bus.dataout_B} - {{DATA_W{1'b0}}, cy_q};
            OP_AND: ext = {1'b0, bus.dataout_A & bus.dataout_B};
            OP_OR:  ext = {1'b0, bus.dataout_A | bus.dataout_B};
            OP_XOR: ext = {1'b0, bus.dataout_A ^ bus.dataout_B};
            OP_NOT: ext = {1'b0, ~bus.dataout_A};
            OP_INR: ext = {1'b0, bus.dataout_A} + ONE;
            OP_DCR: ext = {1'b0, bus.dataout_A} - ONE;
            OP_RLC: ext = {bus.dataout_A[DATA_W-1], bus.dataout_A[DATA_W-2:0], bus.dataout_A[DATA_W-1]};
            OP_RRC: ext = {bus.dataout_A[0], bus.dataout_A[0], bus.dataout_A[DATA_W-1:1]};
            OP_PSB: ext = {1'b0, bus.dataout_B};
            default: ext = '0;
          endcase
          case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
              res_d   = ext[DATA_W-1:0];
              cy_d    = ext[DATA_W];
              zsp_v   = ext[DATA_W-1:0];
              upd_zsp = 1'b1;
            end
            OP_CMP: begin
              cy_d    = ext[DATA_W];
              zsp_v   = ext[DATA_W-1:0];
              upd_zsp = 1'b1;
            end
            OP_INR, OP_DCR, OP_PSB: begin
              res_d   = ext[DATA_W-1:0];
              zsp_v   = ext[DATA_W-1:0];
              upd_zsp = 1'b1;
            end
            OP_RLC, OP_RRC: begin
              res_d = ext[DATA_W-1:0];
              cy_d  = ext[DATA_W];
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
              done_d  = 1'b0;
              state_d = MUL_RUN;
              b_d     = bus.dataout_B;
              plo_d   = bus.dataout_A;
              phi_d   = '0;
              cnt_d   = '0;
            end
`else
            OP_MUL: ;
`endif
            OP_NOP: ;
            default: ;
          endcase
`ifdef ALU_MUL_EN
          if (op != OP_CMP && op != OP_NOP && op != OP_MUL) hi_d = '0;
`endif
        end
      end
`ifdef ALU_MUL_EN
      MUL_RUN: begin
        plo_d = mul_lo;
        phi_d = mul_hi;
        cnt_d = cnt_q + CNT_W'(1);
        if (mul_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          res_d   = mul_lo;
          hi_d    = mul_hi;
          cy_d    = (mul_hi != '0);
          z_d     = ({mul_hi, mul_lo} == '0);
          s_d     = mul_lo[DATA_W-1];
          p_d     = ~^mul_lo;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (upd_zsp) begin
      z_d = (zsp_v == '0);
      s_d = zsp_v[DATA_W-1];
      p_d = ~^zsp_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      cy_q   <= 1'b0;
      z_q    <= 1'b0;
      s_q    <= 1'b0;
      p_q    <= 1'b0;
      done_q <= 1'b0;
`ifdef ALU_MUL_EN
      hi_q   <= '0;
      b_q    <= '0;
      plo_q  <= '0;
      phi_q  <= '0;
      cnt_q  <= '0;
`endif
    end else begin
      res_q  <= res_d;
      cy_q   <= cy_d;
      z_q    <= z_d;
      s_q    <= s_d;
      p_q    <= p_d;
      done_q <= done_d;
`ifdef ALU_MUL_EN
      hi_q   <= hi_d;
      b_q    <= b_d;
      plo_q  <= plo_d;
      phi_q  <= phi_d;
      cnt_q  <= cnt_d;
`endif
    end
  end

  assign bus.ALU_IN  = res_q;
  assign bus.done    = done_q;
  assign bus.flag_cy = cy_q;
  assign bus.flag_z  = z_q;
  assign bus.flag_s  = s_q;
  assign bus.flag_p  = p_q;
`ifdef ALU_MUL_EN
  assign bus.res_hi  = hi_q;
  assign bus.busy    = (state_q == MUL_RUN);
`else
  assign bus.res_hi  = '0;
  assign bus.busy    = 1'b0;
`endif

endmodule
